// File: rtl/cpu_mem_host.sv
// Environment-side memory and control host for the 16-bit pipelined CPU.
// Serves fetches and data accesses from two 256x16 RAMs and runs a program from go until HALT or the cycle limit.
module cpu_mem_host #(
  parameter logic [4:0]  HALT_OP      = 5'b00001,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [15:0] MAX_CYCLES   = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_dataout,
  input  logic        d_we,
  output logic [15:0] d_datain,
  output logic        cpu_reset,
  output logic        enable,
  output logic        start,
  input  logic        h_sel,
  input  logic [7:0]  h_addr,
  input  logic [15:0] h_wdata,
  input  logic        h_we,
  output logic [15:0] h_rdata,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRST   = 3'd1,
    S_CSTART = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] iram [256];
  logic [15:0] dram [256];
  logic [7:0]  drain_q;
  logic        cpu_reset_q, enable_q, start_q, busy_q, done_q, timeout_q;
  logic [15:0] cycles_q, h_rdata_q;
  logic [15:0] cycles_d;
  logic        halt_fetch;

  assign i_datain   = iram[i_addr];
  assign d_datain   = dram[d_addr];
  assign halt_fetch = (i_datain[15:11] == HALT_OP);
  assign cycles_d   = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

  assign cpu_reset = cpu_reset_q;
  assign enable    = enable_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;
  assign h_rdata   = h_rdata_q;
  assign state_dbg = state_q;

  // busy_q gates the two write ports so host and CPU never write DRAM in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (h_we && !busy_q && !h_sel) iram[h_addr] <= h_wdata;
      if (h_we && !busy_q && h_sel)  dram[h_addr] <= h_wdata;
      else if (d_we && busy_q)       dram[d_addr] <= d_dataout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cpu_reset_q <= 1'b0;
      enable_q    <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= 16'd0;
      drain_q     <= 8'd0;
      h_rdata_q   <= 16'd0;
    end else begin
      h_rdata_q <= h_sel ? dram[h_addr] : iram[h_addr];
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            state_q     <= S_CRST;
            cpu_reset_q <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= 16'd0;
          end
        end
        S_CRST: begin
          state_q     <= S_CSTART;
          cpu_reset_q <= 1'b1;
          enable_q    <= 1'b1;
          start_q     <= 1'b1;
        end
        S_CSTART: begin
          state_q <= S_RUN;
          start_q <= 1'b0;
        end
        S_RUN: begin
          cycles_q <= cycles_d;
          // A HALT fetched on the last allowed cycle still counts as a clean finish.
          if (halt_fetch) begin
            state_q <= S_DRAIN;
            drain_q <= 8'(DRAIN_CYCLES);
          end else if (cycles_q == MAX_CYCLES - 16'd1) begin
            state_q   <= S_DONE;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q - 8'd1;
          if (drain_q == 8'd1) begin
            state_q  <= S_DONE;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_mem_host.md
Name: cpu_mem_host

Overview:
- Environment-side counterpart of the 16-bit pipelined CPU's memory interface: serves instruction fetches (i_addr -> i_datain) and data accesses (d_addr/d_dataout/d_we -> d_datain) from two 256x16 RAMs.
- Also sequences the CPU control pins (reset, enable, start), detects HALT and reports completion with a cycle count.
- A host port preloads programs and data and reads back results, replacing hand-driven i_datain stimulus in CPU benches and on the FPGA top level.

Parameters:
- HALT_OP, 5'b00001, opcode in i_datain[15:11] that ends a run.
- DRAIN_CYCLES, 4, cycles waited after HALT fetch so in-flight instructions retire.
- MAX_CYCLES, 16'd1000, RUN-cycle limit before forced stop.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_addr  in  8  CPU fetch address (pc).
- i_datain  out  16  instruction to CPU, combinational read of IRAM[i_addr].
- d_addr  in  8  CPU data address.
- d_dataout  in  16  CPU store data.
- d_we  in  1  CPU store strobe.
- d_datain  out  16  combinational read of DRAM[d_addr].
- cpu_reset  out  1  CPU reset, active-low (0 = CPU held in reset).
- enable  out  1  CPU enable.
- start  out  1  CPU start pulse.
- h_sel  in  1  host target: 0 = IRAM, 1 = DRAM.
- h_addr  in  8  host address.
- h_wdata  in  16  host write data.
- h_we  in  1  host write strobe.
- h_rdata  out  16  host read data, registered.
- go  in  1  begin run.
- busy  out  1  run in progress.
- done  out  1  run finished.
- timeout  out  1  run ended by MAX_CYCLES.
- cycles  out  16  RUN cycle count.

Behaviour:
- Reset: state=IDLE, cpu_reset=0, enable=0, start=0, busy=0, done=0, timeout=0, cycles=0, h_rdata=0. RAM contents are not cleared.
- Reads on i_datain and d_datain are combinational, with zero latency, as the CPU expects.
- Writes to both RAMs are synchronous on the rising edge.
- h_rdata <= (h_sel ? DRAM : IRAM)[h_addr] every cycle. Latency is 1 cycle, valid in all states.
- Host writes are accepted only when busy=0. They are silently dropped while busy=1.
- CPU d_we writes DRAM only when busy=1. d_we is ignored in IDLE/DONE, so host and CPU writes never collide.
- FSM:
  - IDLE: cpu_reset=0, enable=0. go=1 -> CRST.
  - CRST (1 cycle): busy=1, cpu_reset=0; clear done, timeout and cycles -> CSTART.
  - CSTART (1 cycle): cpu_reset=1, enable=1, start=1 -> RUN.
  - RUN: enable=1, start=0, cycles increments each cycle.
    - i_datain[15:11]==HALT_OP -> DRAIN, with drain counter loaded to DRAIN_CYCLES.
    - Otherwise, cycles reaching MAX_CYCLES-1 -> DONE with timeout=1.
    - HALT detection has priority when both occur in the same cycle.
  - DRAIN: enable=1, cycles frozen; drain counter decrements; at 0 -> DONE. CPU stores during DRAIN are still committed.
  - DONE: enable=0, busy=0, done=1; cpu_reset stays 1 so CPU state remains inspectable. go=1 -> CRST (restart).
- go is ignored in CRST, CSTART, RUN and DRAIN.
- cycles saturates at 16'hFFFF and is unaffected by addresses or data.
- reset asserted mid-run: next cycle IDLE, all outputs at reset values. Partially written DRAM is retained.
- i_addr wraps 8'hFF -> 8'h00 naturally with no special handling.

Test Plan:
- Load and readback: host writes IRAM[0x05]=16'hA5A5 and DRAM[0x10]=16'h1234 in IDLE, then reads both back. h_rdata shows each value exactly 1 cycle after its address is presented.
- Basic run: IRAM[0..3]=NOP, IRAM[4]={HALT_OP,11'b0}, pulse go.
  - cpu_reset is low for 1 cycle, then start is high for exactly 1 cycle.
  - Once pc reaches 4 the DRAIN lasts 4 cycles, then done=1, enable=0 and cycles=5.
- CPU store and busy lockout: program stores gr1=16'h0012 to DRAM[0x20]. Issue a host write of 16'hFFFF to 0x20 while busy. After done, the host reads 16'h0012 (host write dropped).
- Timeout: IRAM filled with NOP, MAX_CYCLES=20. Required result: done=1, timeout=1, cycles=20.
- Reset mid-run: assert reset during RUN. Next cycle state is IDLE, enable=0, busy=0 and cycles=0, and IRAM contents are intact on readback.
- Restart from DONE: go re-runs the same program. done drops for the run and cycles repeats the identical value.
